// File: rtl/aos_sr_app_guard.sv
// Per-app SoftReg guard: forwards requests and guarantees exactly one response per accepted read.
// Substitutes a synthetic response when the app is disabled or times out, and drops late app responses.
package aos_sr_pkg;
  typedef struct packed {
    logic        valid;
    logic        isWrite;
    logic [31:0] addr;
    logic [63:0] data;
  } SoftRegReq;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } SoftRegResp;
endpackage

module aos_sr_app_guard
  import aos_sr_pkg::*;
#(
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          TIMEOUT_CYCLES  = 1024,
  parameter logic [63:0] TIMEOUT_DATA    = 64'hDEAD_DEAD_DEAD_DEAD,
  parameter logic [63:0] DISABLED_DATA   = 64'hD15A_B1ED_D15A_B1ED,
  parameter int          CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 app_enable,
  input  SoftRegReq            sr_req_in,
  output SoftRegReq            sr_req_to_app,
  input  SoftRegResp           sr_resp_from_app,
  output SoftRegResp           sr_resp_out,
  output logic [CNT_WIDTH-1:0] timeout_count,
  output logic [CNT_WIDTH-1:0] spurious_count,
  output logic                 overflow_err,
  output logic                 busy
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [MAX_OUTSTANDING-1:0] fwd_q, fwd_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]                count_q, count_d, nfwd0_q, nfwd0_d;
  logic [MAX_OUTSTANDING-1:0] stale_q, stale_d;
  logic [TW-1:0]              timer_q, timer_d;
  logic [CNT_WIDTH-1:0]       tmo_cnt_q, tmo_cnt_d, spur_cnt_q, spur_cnt_d;
  logic                       ovf_q, ovf_d;
  SoftRegReq                  req_q, req_d;
  SoftRegResp                 resp_q, resp_d;

  logic head_fwd, q_empty, q_full, app_v, stale_drop, fwd_resp, spur;
  logic synth_dis, synth_tmo, pop, stale_inc, rd_req, wr_fwd, push, push_fwd;

  always_comb begin
    head_fwd   = fwd_q[rd_ptr_q];
    q_empty    = (count_q == '0);
    q_full     = (count_q == (PW+1)'(MAX_OUTSTANDING));
    app_v      = sr_resp_from_app.valid;
    stale_drop = app_v && (stale_q != '0);
    fwd_resp   = app_v && !stale_drop && !q_empty && head_fwd;
    spur       = app_v && !stale_drop && !fwd_resp;
    // Disabled takes precedence over timeout when both would apply.
    synth_dis  = !fwd_resp && !q_empty && (!head_fwd || !app_enable);
    synth_tmo  = !fwd_resp && !q_empty && head_fwd && app_enable &&
                 (timer_q == TW'(TIMEOUT_CYCLES - 1));
    pop        = fwd_resp || synth_dis || synth_tmo;
    stale_inc  = (synth_dis && head_fwd) || synth_tmo;

    rd_req   = sr_req_in.valid && !sr_req_in.isWrite;
    wr_fwd   = sr_req_in.valid && sr_req_in.isWrite && app_enable;
    push     = rd_req && !(q_full && !pop);
    // A forwarded read must never overtake a pending unforwarded one.
    push_fwd = app_enable && (nfwd0_q == '0);

    fwd_d = fwd_q;
    if (push) fwd_d[wr_ptr_q] = push_fwd;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
    nfwd0_d  = nfwd0_q + (PW+1)'(push && !push_fwd) - (PW+1)'(pop && !head_fwd);

    stale_d = stale_q;
    if (stale_inc && !stale_drop && !(&stale_q)) stale_d = stale_q + MAX_OUTSTANDING'(1);
    else if (stale_drop && !stale_inc)           stale_d = stale_q - MAX_OUTSTANDING'(1);

    timer_d = timer_q;
    if (pop || q_empty)            timer_d = '0;
    else if (head_fwd && app_enable) timer_d = timer_q + TW'(1);

    tmo_cnt_d  = (synth_tmo && !(&tmo_cnt_q)) ? tmo_cnt_q + CNT_WIDTH'(1) : tmo_cnt_q;
    spur_cnt_d = (spur && !(&spur_cnt_q)) ? spur_cnt_q + CNT_WIDTH'(1) : spur_cnt_q;
    ovf_d      = ovf_q || (rd_req && !push);

    req_d = '0;
    if (wr_fwd || (push && push_fwd)) req_d = sr_req_in;

    resp_d = '0;
    resp_d.valid = pop;
    if (fwd_resp)       resp_d.data = sr_resp_from_app.data;
    else if (synth_dis) resp_d.data = DISABLED_DATA;
    else if (synth_tmo) resp_d.data = TIMEOUT_DATA;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      nfwd0_q    <= '0;
      stale_q    <= '0;
      timer_q    <= '0;
      tmo_cnt_q  <= '0;
      spur_cnt_q <= '0;
      ovf_q      <= 1'b0;
      req_q      <= '0;
      resp_q     <= '0;
    end else begin
      fwd_q      <= fwd_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      nfwd0_q    <= nfwd0_d;
      stale_q    <= stale_d;
      timer_q    <= timer_d;
      tmo_cnt_q  <= tmo_cnt_d;
      spur_cnt_q <= spur_cnt_d;
      ovf_q      <= ovf_d;
      req_q      <= req_d;
      resp_q     <= resp_d;
    end
  end

  assign sr_req_to_app  = req_q;
  assign sr_resp_out    = resp_q;
  assign timeout_count  = tmo_cnt_q;
  assign spurious_count = spur_cnt_q;
  assign overflow_err   = ovf_q;
  assign busy           = (count_q != '0);
endmodule

// File: tb/tb_aos_sr_app_guard.sv
// Directed-vector bench for aos_sr_app_guard; a negedge monitor checks DUT outputs against scoreboard queues.
module tb_aos_sr_app_guard;
  import aos_sr_pkg::*;

  localparam logic [63:0] TD = 64'hDEAD_DEAD_DEAD_DEAD;
  localparam logic [63:0] DD = 64'hD15A_B1ED_D15A_B1ED;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        app_enable = 1'b1;
  SoftRegReq   req_in = '0;
  SoftRegReq   req_to_app;
  SoftRegResp  resp_from_app = '0;
  SoftRegResp  resp_out;
  logic [15:0] timeout_count, spurious_count;
  logic        overflow_err, busy;

  int vectors = 0;
  int miscompares = 0;
  SoftRegReq   exp_req[$];
  logic [63:0] exp_resp[$];

  always #5 clk = ~clk;

  aos_sr_app_guard #(
    .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16), .TIMEOUT_DATA(TD),
    .DISABLED_DATA(DD), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .app_enable(app_enable),
    .sr_req_in(req_in), .sr_req_to_app(req_to_app),
    .sr_resp_from_app(resp_from_app), .sr_resp_out(resp_out),
    .timeout_count(timeout_count), .spurious_count(spurious_count),
    .overflow_err(overflow_err), .busy(busy)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: output valid with nothing expected", name);
  endtask

  // Monitor: pops the scoreboard whenever an output is valid, checks idle outputs are all zero.
  always @(negedge clk) begin
    SoftRegReq   er;
    logic [63:0] ed;
    if (req_to_app.valid) begin
      if (exp_req.size() == 0) flag("unexpected_req");
      else begin
        er = exp_req.pop_front();
        check("req_to_app", 128'(req_to_app), 128'(er));
      end
    end else check("req_idle_zero", 128'(req_to_app), 128'd0);
    if (resp_out.valid) begin
      if (exp_resp.size() == 0) flag("unexpected_resp");
      else begin
        ed = exp_resp.pop_front();
        check("resp_out", 128'(resp_out), 128'({1'b1, ed}));
      end
    end else check("resp_idle_zero", 128'(resp_out), 128'd0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic rd(input logic [31:0] a, input bit fwd);
    req_in = '{valid: 1'b1, isWrite: 1'b0, addr: a, data: 64'h0};
    if (fwd) exp_req.push_back(req_in);
    tick();
    req_in = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] d, input bit fwd);
    req_in = '{valid: 1'b1, isWrite: 1'b1, addr: a, data: d};
    if (fwd) exp_req.push_back(req_in);
    tick();
    req_in = '0;
  endtask

  task automatic app(input logic [63:0] d);
    resp_from_app = '{valid: 1'b1, data: d};
    tick();
    resp_from_app = '0;
  endtask

  initial begin
    // Reset state
    idle(3);
    check("rst_timeout_count", 128'(timeout_count), 128'd0);
    check("rst_spurious_count", 128'(spurious_count), 128'd0);
    check("rst_overflow", 128'(overflow_err), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    rst = 1'b0;
    idle(2);

    // Normal read and forwarded write
    rd(32'h10, 1'b1);
    exp_resp.push_back(64'h1234);
    check("normal_busy", 128'(busy), 128'd1);
    idle(4);
    app(64'h1234);
    idle(2);
    check("normal_busy_clear", 128'(busy), 128'd0);
    wr(32'h20, 64'hCAFE, 1'b1);
    idle(2);

    // Timeout: fires exactly on the 16th cycle at head
    rd(32'h30, 1'b1);
    exp_resp.push_back(TD);
    idle(15);
    check("tmo_not_early", 128'(busy), 128'd1);
    idle(1);
    check("tmo_popped", 128'(busy), 128'd0);
    idle(2);
    check("tmo_count", 128'(timeout_count), 128'd1);
    app(64'h55);
    idle(2);
    check("tmo_late_not_spurious", 128'(spurious_count), 128'd0);

    // Disabled app: nothing forwarded, three disabled responses
    app_enable = 1'b0;
    rd(32'h100, 1'b0); exp_resp.push_back(DD);
    rd(32'h104, 1'b0); exp_resp.push_back(DD);
    rd(32'h108, 1'b0); exp_resp.push_back(DD);
    wr(32'h10C, 64'h77, 1'b0);
    idle(3);
    check("dis_busy", 128'(busy), 128'd0);

    // Disable with two forwarded reads in flight
    app_enable = 1'b1;
    rd(32'h40, 1'b1); exp_resp.push_back(DD);
    rd(32'h44, 1'b1); exp_resp.push_back(DD);
    app_enable = 1'b0;
    idle(3);
    app_enable = 1'b1;
    check("mid_busy", 128'(busy), 128'd0);
    app(64'h111);
    app(64'h222);
    rd(32'h48, 1'b1); exp_resp.push_back(64'hABCD);
    idle(3);
    app(64'hABCD);
    idle(2);
    check("mid_spurious", 128'(spurious_count), 128'd0);
    check("mid_timeout", 128'(timeout_count), 128'd1);

    // Overflow: fifth back-to-back read is dropped
    check("ovf_before", 128'(overflow_err), 128'd0);
    for (int i = 0; i < 5; i++) begin
      rd(32'h200 + 32'(i * 4), i < 4);
      if (i < 4) exp_resp.push_back(TD);
    end
    check("ovf_set", 128'(overflow_err), 128'd1);
    idle(70);
    check("ovf_timeouts", 128'(timeout_count), 128'd5);
    check("ovf_busy", 128'(busy), 128'd0);
    for (int i = 0; i < 4; i++) app(64'h300 + 64'(i));
    idle(2);
    check("ovf_stale_flushed", 128'(spurious_count), 128'd0);
    check("ovf_sticky", 128'(overflow_err), 128'd1);

    // Spurious response with empty queue
    app(64'h77);
    idle(1);
    check("spurious_count", 128'(spurious_count), 128'd1);

    // App response on the exact timeout cycle wins
    rd(32'h50, 1'b1);
    exp_resp.push_back(64'h9999);
    idle(15);
    app(64'h9999);
    idle(2);
    check("coinc_timeout", 128'(timeout_count), 128'd5);
    check("coinc_busy", 128'(busy), 128'd0);

    // Reset mid-operation discards the pending read
    rd(32'h60, 1'b1);
    idle(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_busy", 128'(busy), 128'd0);
    check("rst2_timeout_count", 128'(timeout_count), 128'd0);
    check("rst2_spurious_count", 128'(spurious_count), 128'd0);
    check("rst2_overflow", 128'(overflow_err), 128'd0);
    idle(30);

    check("drain_req", 128'(exp_req.size()), 128'd0);
    check("drain_resp", 128'(exp_resp.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
